// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states: one outstanding transaction at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Which requester owns the current transaction.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Default byte address of the LED toggle register.
    localparam logic [31:0] TOGGLE_ADDR_DEFAULT = 32'd52;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the datapath/BRAM side and the arbiter.
//
// Handshake: a requester raises req with stable addr/we/wdata and holds
// them until it sees a one-cycle ack; a req still high in the cycle after
// ack is a new request. Reads are answered later by a one-cycle rvalid,
// with rdata holding its value until the next read for that requester.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic [BE_W-1:0]   d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] toggle_value;
    state_t            dbg_state;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, toggle_value, dbg_state
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, toggle_value, dbg_state
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant choice between fetch and data, with a data-streak limit so a
// waiting fetch is not starved by back-to-back data accesses.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic fast_clk,
    input  logic resetn,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_strobe,   // high while the arbiter is sampling in IDLE
    output logic grant_d
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] d_streak;

    assign grant_d = d_req && !(i_req && (d_streak == STREAK_MAX));

    // Count data grants made over a waiting fetch; clear once fetch is served or absent.
    always_ff @(posedge fast_clk or negedge resetn) begin
        if (!resetn) begin
            d_streak <= '0;
        end else if (grant_strobe) begin
            if (!i_req) begin
                d_streak <= '0;
            end else if (grant_d) begin
                if (d_streak != STREAK_MAX) begin
                    d_streak <= d_streak + 1'b1;
                end
            end else begin
                d_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between fetch and memory-access stages and
// decodes the LED toggle register.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_D_STREAK = 4,
    parameter logic [ADDR_W-1:0] TOGGLE_ADDR = ADDR_W'(TOGGLE_ADDR_DEFAULT)
) (
    input logic fast_clk,
    input logic resetn,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic              hit_q;
    logic [BE_W-1:0]   we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        lat_cnt;

    logic              grant_strobe;
    logic              grant_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_hit;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .fast_clk     (fast_clk),
        .resetn       (resetn),
        .i_req        (bus.i_req),
        .d_req        (bus.d_req),
        .grant_strobe (grant_strobe),
        .grant_d      (grant_d)
    );

    // Mux the winning requester's address and write payload.
    always_comb begin
        sel_addr  = bus.i_addr;
        sel_we    = '0;
        sel_wdata = '0;
        if (grant_d) begin
            sel_addr  = bus.d_addr;
            sel_we    = bus.d_we;
            sel_wdata = bus.d_wdata;
        end
    end

    assign sel_hit       = (sel_addr == TOGGLE_ADDR);
    assign bus.dbg_state = state_q;

    // State register.
    always_ff @(posedge fast_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: writes finish after ISSUE, reads wait out the BRAM latency.
    always_comb begin
        state_d      = state_q;
        grant_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                grant_strobe = 1'b1;
                if (bus.i_req || bus.d_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = (we_q != '0) ? IDLE : WAIT;
            WAIT:    if (lat_cnt == LAT_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and transaction context, updated per state.
    always_ff @(posedge fast_clk or negedge resetn) begin
        if (!resetn) begin
            owner_q          <= OWN_I;
            hit_q            <= 1'b0;
            we_q             <= '0;
            wdata_q          <= '0;
            lat_cnt          <= '0;
            bus.i_ack        <= 1'b0;
            bus.d_ack        <= 1'b0;
            bus.i_rvalid     <= 1'b0;
            bus.d_rvalid     <= 1'b0;
            bus.i_rdata      <= '0;
            bus.d_rdata      <= '0;
            bus.mem_en       <= 1'b0;
            bus.mem_we       <= '0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.toggle_value <= '0;
        end else begin
            bus.i_ack    <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        owner_q       <= grant_d ? OWN_D : OWN_I;
                        hit_q         <= sel_hit;
                        we_q          <= sel_we;
                        wdata_q       <= sel_wdata;
                        lat_cnt       <= '0;
                        bus.i_ack     <= !grant_d;
                        bus.d_ack     <= grant_d;
                        // The toggle register is not backed by BRAM, so keep the RAM quiet.
                        bus.mem_en    <= !sel_hit;
                        bus.mem_we    <= sel_hit ? '0 : sel_we;
                        bus.mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_wdata <= sel_wdata;
                    end
                end
                ISSUE: begin
                    if (hit_q && (we_q != '0)) begin
                        for (int b = 0; b < BE_W; b++) begin
                            if (we_q[b]) begin
                                bus.toggle_value[8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (owner_q == OWN_D) begin
                            bus.d_rdata  <= hit_q ? bus.toggle_value : bus.mem_rdata;
                            bus.d_rvalid <= 1'b1;
                        end else begin
                            bus.i_rdata  <= hit_q ? bus.toggle_value : bus.mem_rdata;
                            bus.i_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-1 BRAM model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic fast_clk = 1'b0;
    logic resetn   = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic [31:0] ram [0:63];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter dut (
        .fast_clk (fast_clk),
        .resetn   (resetn),
        .bus      (bus.slave)
    );

    // Clock and watchdog.
    always #5 fast_clk = ~fast_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // BRAM model, one cycle read latency, byte-enabled writes.
    always @(posedge fast_clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= ram[bus.mem_addr[7:2]];
        end
    end

    task automatic step();
        @(negedge fast_clk);
    endtask

    task automatic drop_all();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = '0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drop_all();
        repeat (3) step();
        total_cnt++;
        if ({bus.i_ack, bus.d_ack, bus.i_rvalid, bus.d_rvalid, bus.mem_en} !== 5'b0)
            $display("FAIL reset_pulses: got %b required 00000", {bus.i_ack, bus.d_ack, bus.i_rvalid, bus.d_rvalid, bus.mem_en});
        else pass_cnt++;
        total_cnt++;
        if ({bus.i_rdata, bus.d_rdata, bus.toggle_value} !== 96'h0)
            $display("FAIL reset_data: got %h %h %h required 0", bus.i_rdata, bus.d_rdata, bus.toggle_value);
        else pass_cnt++;
        total_cnt++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 68'h0 || bus.dbg_state !== IDLE)
            $display("FAIL reset_mem: got we=%h addr=%h st=%0d required 0", bus.mem_we, bus.mem_addr, bus.dbg_state);
        else pass_cnt++;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_fetch_read();
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        step();  // cycle 1
        total_cnt++;
        if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0)
            $display("FAIL fetch_ack: got i=%b d=%b required i=1 d=0", bus.i_ack, bus.d_ack);
        else pass_cnt++;
        total_cnt++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 4'h0)
            $display("FAIL fetch_mem: got en=%b addr=%h we=%h required 1 10 0", bus.mem_en, bus.mem_addr, bus.mem_we);
        else pass_cnt++;
        drop_all();
        step();  // cycle 2
        total_cnt++;
        if (bus.i_rvalid !== 1'b0 || bus.i_ack !== 1'b0)
            $display("FAIL fetch_early: got rvalid=%b ack=%b required 0 0", bus.i_rvalid, bus.i_ack);
        else pass_cnt++;
        step();  // cycle 3
        total_cnt++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h00500093)
            $display("FAIL fetch_rdata: got v=%b %h required 1 00500093", bus.i_rvalid, bus.i_rdata);
        else pass_cnt++;
        step();  // cycle 4
        total_cnt++;
        if (bus.i_rvalid !== 1'b0)
            $display("FAIL fetch_pulse: got %b required 0", bus.i_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'h40;
        step();  // cycle 1
        total_cnt++;
        if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.mem_addr !== 32'h40)
            $display("FAIL sim_grant: got d=%b i=%b addr=%h required 1 0 40", bus.d_ack, bus.i_ack, bus.mem_addr);
        else pass_cnt++;
        bus.d_req = 1'b0; bus.d_addr = '0;
        step(); step();  // cycle 3
        total_cnt++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hCAFE0040)
            $display("FAIL sim_drdata: got v=%b %h required 1 cafe0040", bus.d_rvalid, bus.d_rdata);
        else pass_cnt++;
        total_cnt++;
        if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h00500093)
            $display("FAIL sim_nonowner: got v=%b %h required 0 00500093", bus.i_rvalid, bus.i_rdata);
        else pass_cnt++;
        step(); step();  // cycle 5
        total_cnt++;
        if (bus.i_ack !== 1'b1)
            $display("FAIL sim_iack: got %b required 1", bus.i_ack);
        else pass_cnt++;
        drop_all();
        step(); step();  // cycle 7
        total_cnt++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h00500093)
            $display("FAIL sim_irdata: got v=%b %h required 1 00500093", bus.i_rvalid, bus.i_rdata);
        else pass_cnt++;
        step();  // cycle 8, idle
    endtask

    task automatic test_starvation();
        int d_acks = 0;
        int ack_cyc = 0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'h40;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus.d_ack) d_acks++;
            if (bus.i_ack) begin
                ack_cyc = c;
                break;
            end
        end
        bus.i_req = 1'b0; bus.i_addr = '0;
        total_cnt++;
        if (d_acks !== 4)
            $display("FAIL starve_dacks: got %0d required 4", d_acks);
        else pass_cnt++;
        total_cnt++;
        if (ack_cyc !== 17)
            $display("FAIL starve_iack_cycle: got %0d required 17", ack_cyc);
        else pass_cnt++;
        step(); step();  // cycle 19
        total_cnt++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h00500093)
            $display("FAIL starve_irdata: got v=%b %h required 1 00500093", bus.i_rvalid, bus.i_rdata);
        else pass_cnt++;
        step(); step();  // cycle 21
        total_cnt++;
        if (bus.d_ack !== 1'b1)
            $display("FAIL starve_dresume: got %b required 1", bus.d_ack);
        else pass_cnt++;
        drop_all();
        step(); step();  // cycle 23
        total_cnt++;
        if (bus.d_rvalid !== 1'b1)
            $display("FAIL starve_drvalid: got %b required 1", bus.d_rvalid);
        else pass_cnt++;
        step();  // cycle 24, idle
    endtask

    task automatic test_mmio();
        bus.d_req = 1'b1; bus.d_we = 4'hF; bus.d_addr = 32'd52; bus.d_wdata = 32'h1;
        step();  // c1
        total_cnt++;
        if (bus.d_ack !== 1'b1 || bus.mem_en !== 1'b0)
            $display("FAIL mmio_wr_issue: got ack=%b en=%b required 1 0", bus.d_ack, bus.mem_en);
        else pass_cnt++;
        drop_all();
        step();  // c2
        total_cnt++;
        if (bus.toggle_value !== 32'h1 || bus.d_rvalid !== 1'b0)
            $display("FAIL mmio_wr_value: got %h v=%b required 00000001 0", bus.toggle_value, bus.d_rvalid);
        else pass_cnt++;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 32'd52;
        step();  // c3
        total_cnt++;
        if (bus.d_ack !== 1'b1 || bus.mem_en !== 1'b0)
            $display("FAIL mmio_rd_issue: got ack=%b en=%b required 1 0", bus.d_ack, bus.mem_en);
        else pass_cnt++;
        drop_all();
        step(); step();  // c5
        total_cnt++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1)
            $display("FAIL mmio_rd_data: got v=%b %h required 1 00000001", bus.d_rvalid, bus.d_rdata);
        else pass_cnt++;
        step();  // c6
        bus.d_req = 1'b1; bus.d_we = 4'b0010; bus.d_addr = 32'd52; bus.d_wdata = 32'hFF00;
        step();  // c7
        drop_all();
        step();  // c8
        total_cnt++;
        if (bus.toggle_value !== 32'hFF01)
            $display("FAIL mmio_byte_merge: got %h required 0000ff01", bus.toggle_value);
        else pass_cnt++;
    endtask

    task automatic test_byte_write();
        bus.d_req = 1'b1; bus.d_we = 4'b0100; bus.d_addr = 32'h22; bus.d_wdata = 32'hAABBCCDD;
        step();  // c1
        total_cnt++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'b0100 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'hAABBCCDD)
            $display("FAIL bw_issue: got en=%b we=%b addr=%h wd=%h required 1 0100 20 aabbccdd", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else pass_cnt++;
        drop_all();
        step();  // c2, idle again
        total_cnt++;
        if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h1 || bus.dbg_state !== IDLE)
            $display("FAIL bw_no_rvalid: got v=%b %h st=%0d required 0 00000001 0", bus.d_rvalid, bus.d_rdata, bus.dbg_state);
        else pass_cnt++;
        bus.i_req = 1'b1; bus.i_addr = 32'h20;
        step();  // c3
        drop_all();
        step(); step();  // c5
        total_cnt++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h10BB0008 || bus.d_rvalid !== 1'b0)
            $display("FAIL bw_readback: got v=%b %h dv=%b required 1 10bb0008 0", bus.i_rvalid, bus.i_rdata, bus.d_rvalid);
        else pass_cnt++;
        step();  // c6
    endtask

    task automatic test_reset_mid_read();
        int stray = 0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        step();  // c1
        drop_all();
        step();  // c2, WAIT
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({bus.i_ack, bus.i_rvalid, bus.mem_en} !== 3'b0 || bus.i_rdata !== 32'h0 || bus.toggle_value !== 32'h0 || bus.dbg_state !== IDLE)
            $display("FAIL rst_mid_outputs: got ack=%b v=%b en=%b rd=%h tog=%h st=%0d required all 0", bus.i_ack, bus.i_rvalid, bus.mem_en, bus.i_rdata, bus.toggle_value, bus.dbg_state);
        else pass_cnt++;
        step(); step();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.i_rvalid || bus.d_rvalid || bus.i_ack || bus.d_ack) stray++;
        end
        total_cnt++;
        if (stray !== 0)
            $display("FAIL rst_mid_stray: got %0d pulses required 0", stray);
        else pass_cnt++;
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        step();  // c1
        total_cnt++;
        if (bus.i_ack !== 1'b1 || bus.mem_addr !== 32'h40)
            $display("FAIL rst_mid_ack: got %b addr=%h required 1 40", bus.i_ack, bus.mem_addr);
        else pass_cnt++;
        drop_all();
        step(); step();  // c3
        total_cnt++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hCAFE0040)
            $display("FAIL rst_mid_rdata: got v=%b %h required 1 cafe0040", bus.i_rvalid, bus.i_rdata);
        else pass_cnt++;
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
        ram[4]  = 32'h00500093;
        ram[16] = 32'hCAFE0040;
        bus.mem_rdata = '0;
        drop_all();
        test_reset();
        test_fetch_read();
        test_simultaneous();
        test_starvation();
        test_mmio();
        test_byte_write();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port block RAM between the fetch stage (read-only) and the memory-access stage (read/write) of the pipelined RISC-V core.
- Sequences each access as a single outstanding transaction, hiding BRAM read latency behind a req/ack/rvalid handshake.
- Decodes one memory-mapped register, the LED toggle value, at TOGGLE_ADDR.
- Sits between the datapath and the BRAM and runs on fast_clk.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- READ_LATENCY, 1, BRAM cycles from mem_en to valid mem_rdata; legal range 1..3.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch request waits.
- TOGGLE_ADDR, 32'd52, MMIO address of the toggle register.

Ports:
- fast_clk  in  1  clock.
- resetn  in  1  asynchronous reset, active-low.
- i_req  in  1  fetch read request; held until i_ack.
- i_addr  in  ADDR_W  fetch byte address.
- i_ack  out  1  one-cycle pulse: fetch request accepted.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until d_ack.
- d_we  in  DATA_W/8  byte write enables; 0 means read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only).
- d_rdata  out  DATA_W  data read data.
- mem_en  out  1  BRAM enable.
- mem_we  out  DATA_W/8  BRAM byte write enables.
- mem_addr  out  ADDR_W  BRAM byte address, bits [1:0] forced to 0.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data.
- toggle_value  out  DATA_W  MMIO toggle register.

Behaviour:
- Reset: resetn is asynchronous and active-low; the block is clocked on fast_clk. While resetn is low:
  - FSM goes to IDLE.
  - All outputs, including toggle_value and the streak counter, are 0.
  - Any in-flight transaction is discarded; no ack or rvalid is emitted for it after reset is released.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples i_req and d_req and picks an owner.
  - Latches the owner's address, we and wdata.
  - Moves to ISSUE. Stays in IDLE if neither request is present.
- Arbitration:
  - Data wins over fetch.
  - Exception: when d_streak == MAX_D_STREAK and i_req is high, fetch wins.
  - d_streak increments on each data grant made while i_req is high. It clears on a fetch grant or on any cycle in IDLE with i_req low. It saturates at MAX_D_STREAK.
- ISSUE (exactly 1 cycle):
  - Asserts the owner's ack.
  - BRAM access: mem_en=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_we=latched we, mem_wdata=latched wdata.
  - TOGGLE_ADDR hit (full-address compare): mem_en=0.
    - Write: toggle_value takes the byte-enabled merge of wdata at the end of ISSUE.
    - Read: the response data is toggle_value.
  - Writes (we != 0) return to IDLE; no rvalid is generated.
  - Reads go to WAIT.
- WAIT:
  - Counts READ_LATENCY cycles. On the last one, captures mem_rdata (or toggle_value for an MMIO read) into the owner's rdata register.
  - Then goes to RESP.
- RESP (1 cycle): asserts the owner's rvalid, then returns to IDLE.
- Latency:
  - Read: req seen in IDLE at cycle 0; ack in cycle 1; rvalid in cycle 2+READ_LATENCY.
  - Write: ack in cycle 1; the next request can be sampled in cycle 2.
  - MMIO accesses use identical timing.
- The non-owner's ack, rvalid and rdata stay unchanged. rdata holds its last value until it is overwritten.
- Requester rules:
  - A requester drops or changes req/addr only after seeing ack.
  - A request still asserted in the cycle after ack is treated as a new request.
- Simultaneous i_req and d_req in IDLE: only one is granted. The loser stays pending and must keep req held.

Decomposition:
- Shared package mem_arb_pkg holds:
  - FSM state encoding (IDLE, ISSUE, WAIT, RESP).
  - Owner encoding (OWN_I, OWN_D).
  - Default TOGGLE_ADDR constant.
- One natural sub-module: mem_arb_pick. It contains the combinational grant choice plus the d_streak counter, with inputs i_req, d_req, grant_strobe and output grant_d.

Test Plan:
- Reset then single fetch read: i_req, i_addr=0x10, mem_rdata=0x00500093 (READ_LATENCY=1) -> i_ack cycle 1, mem_en=1 with mem_addr=0x10 cycle 1, i_rvalid with i_rdata=0x00500093 cycle 3.
- Simultaneous requests: i_req and d_req (read, 0x40) both high in cycle 0 -> d_ack cycle 1, d_rvalid cycle 3; i_ack in the cycle after the arbiter's next IDLE.
- Starvation guard: d_req held continuously with new reads, i_req held, MAX_D_STREAK=4 -> exactly 4 d_ack pulses, then i_ack.
- MMIO: data write d_we=4'b1111, d_addr=52, d_wdata=0x1 -> mem_en stays 0, toggle_value=0x1 after ISSUE. A following read of 52 -> d_rdata=0x1. A write with d_we=4'b0010 and wdata=0xFF00 -> toggle_value=0xFF01.
- Byte write to RAM: d_we=4'b0100, d_addr=0x22 -> mem_we=4'b0100, mem_addr=0x20, no d_rvalid.
- Reset mid-read: resetn low during WAIT -> all outputs 0 immediately; no rvalid after release; the next request completes with normal timing.
